// File: rtl/forward_unit_n.sv
// Purpose : forwarding and load-use hazard unit; tracks DEPTH in-flight register writes and resolves NPORTS source operands.
// Latency : zero added latency; fwd_data/fwd_sel/stall/mem_wait are combinational from slot state and ld_*.
// Backpressure: raises stall on a not-yet-ready load match and mem_wait while slot 0 awaits load data; slots only move on adv.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   adv                 pipeline advance (slots shift when high)
//   iss_*               EX-stage producer entering slot 0
//   ld_valid, ld_data   load data returning for slot 0
//   src_addr, rf_data   per-port consumer register and register-file value
//   fwd_data, fwd_sel   per-port resolved operand and its source (0 = RF, k = slot k-1)
//   stall, mem_wait     hazard outputs
//   fwd_cnt, stall_cnt  saturating activity counters (adv cycles only)
module forward_unit_n #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 2,
    localparam int SW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adv,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 iss_load,
    input  logic [DW-1:0]        iss_data,
    input  logic                 ld_valid,
    input  logic [DW-1:0]        ld_data,
    input  logic [NPORTS*AW-1:0] src_addr,
    input  logic [NPORTS*DW-1:0] rf_data,
    output logic [NPORTS*DW-1:0] fwd_data,
    output logic [NPORTS*SW-1:0] fwd_sel,
    output logic                 stall,
    output logic                 mem_wait,
    output logic [15:0]          fwd_cnt,
    output logic [15:0]          stall_cnt
);

    // Slot 0 is the youngest producer (MEM), higher indices are older.
    logic          v_q    [DEPTH];
    logic [AW-1:0] rd_q   [DEPTH];
    logic          ok_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic          v_d    [DEPTH];
    logic [AW-1:0] rd_d   [DEPTH];
    logic          ok_d   [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic [15:0]       fwd_cnt_q, fwd_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [NPORTS-1:0] hz;
    logic [NPORTS-1:0] fwd_hit;
    logic              ld_fill;

    // Load data arriving for a pending load sitting in slot 0.
    assign ld_fill  = v_q[0] & ~ok_q[0] & ld_valid;
    assign mem_wait = v_q[0] & ~ok_q[0] & ~ld_valid;
    assign stall    = |hz;

    // Operand resolution. Slots are scanned oldest to youngest so the
    // youngest match is the last assignment and therefore wins.
    always_comb begin
        fwd_data = '0;
        fwd_sel  = '0;
        hz       = '0;
        fwd_hit  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            fwd_data[p*DW +: DW] = rf_data[p*DW +: DW];
            if (src_addr[p*AW +: AW] != '0) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (v_q[k] && (rd_q[k] == src_addr[p*AW +: AW])) begin
                        fwd_sel[p*SW +: SW] = SW'(k + 1);
                        if (ok_q[k]) begin
                            fwd_data[p*DW +: DW] = data_q[k];
                            hz[p]                = 1'b0;
                        end else if ((k == 0) && ld_valid) begin
                            // Same-cycle bypass of returning load data.
                            fwd_data[p*DW +: DW] = ld_data;
                            hz[p]                = 1'b0;
                        end else begin
                            fwd_data[p*DW +: DW] = rf_data[p*DW +: DW];
                            hz[p]                = 1'b1;
                        end
                    end
                end
            end
            fwd_hit[p] = (fwd_sel[p*SW +: SW] != '0) & ~hz[p];
        end
    end

    // Slot next state: shift on adv, otherwise hold and let slot 0 absorb load data.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k]    = v_q[k];
            rd_d[k]   = rd_q[k];
            ok_d[k]   = ok_q[k];
            data_d[k] = data_q[k];
        end
        if (adv) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]    = v_q[k-1];
                rd_d[k]   = rd_q[k-1];
                ok_d[k]   = ok_q[k-1];
                data_d[k] = data_q[k-1];
                if ((k == 1) && ld_fill) begin
                    ok_d[k]   = 1'b1;
                    data_d[k] = ld_data;
                end
            end
            // A stalled consumer is not issued, so slot 0 takes a bubble.
            v_d[0]    = iss_valid & ~stall;
            rd_d[0]   = iss_rd;
            ok_d[0]   = ~iss_load;
            data_d[0] = iss_data;
        end else if (ld_fill) begin
            ok_d[0]   = 1'b1;
            data_d[0] = ld_data;
        end
    end

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (adv) begin
            if ((|fwd_hit) && (fwd_cnt_q != 16'hFFFF)) begin
                fwd_cnt_d = fwd_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k]    <= 1'b0;
                rd_q[k]   <= '0;
                ok_q[k]   <= 1'b0;
                data_q[k] <= '0;
            end
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k]    <= v_d[k];
                rd_q[k]   <= rd_d[k];
                ok_q[k]   <= ok_d[k];
                data_q[k] <= data_d[k];
            end
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/forward_unit_n.md
# forward_unit_n

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It tracks up to DEPTH in-flight register writes in a shift register, from the EX result onward. For NPORTS consumer source operands it selects the youngest matching producer, or the register-file value when there is no match. It raises `stall` when the youngest match is a load whose data has not arrived, and `mem_wait` while the memory stage is still waiting for load data. It replaces the fixed two-port, select-driven operand muxing in the datapath and also generates the select itself.

## Interface
- `AW`, 5, register address width
- `DW`, 32, data width
- `NPORTS`, 2, number of consumer source operands
- `DEPTH`, 2, producer slots (slot 0 = MEM, slot 1 = WB, …)
- `SW`, localparam = clog2(DEPTH+1), per-port select width
- `clk`  in  1  system clock; the single clock of the block
- `reset`  in  1  synchronous, active-high reset
- `adv`  in  1  pipeline advance; slots shift on a rising edge with adv=1
- `iss_valid`  in  1  EX stage produces a register write this cycle
- `iss_rd`  in  AW  EX destination register
- `iss_load`  in  1  EX instruction is a load; data is not available yet
- `iss_data`  in  DW  EX ALU result; ignored when iss_load=1
- `ld_valid`  in  1  load data for slot 0 is present this cycle
- `ld_data`  in  DW  load data for slot 0
- `src_addr`  in  NPORTS*AW  consumer source registers, port p at [p*AW +: AW]
- `rf_data`  in  NPORTS*DW  register-file read data per port
- `fwd_data`  out  NPORTS*DW  resolved operand per port
- `fwd_sel`  out  NPORTS*SW  0 = register file, k = slot k-1
- `stall`  out  1  hold the consumer; insert a bubble
- `mem_wait`  out  1  slot 0 holds a pending load and ld_valid=0
- `fwd_cnt`  out  16  cycles with adv=1 in which at least one port forwarded, saturating
- `stall_cnt`  out  16  cycles with adv=1 and stall=1, saturating

## Operation
- **Slot contents:** each slot holds `v`, `rd`, `ok` (data ready) and `data`.
- **Shift on adv=1 (rising edge):**
  - slot[k] <= slot[k-1] for k=1..DEPTH-1; slot[DEPTH-1] is discarded.
  - slot[0] <= {iss_valid & ~stall, iss_rd, ~iss_load, iss_data}.
  - If slot 0 is a pending load and ld_valid=1, the entry moving into slot 1 carries ok=1 and data=ld_data.
- **Hold on adv=0:** all slots hold. If slot 0 is valid with ok=0 and ld_valid=1, slot 0 captures ok=1 and data=ld_data.
- **Resolution, per port p (combinational):**
  - If src_addr[p]==0: fwd_sel=0 and fwd_data=rf_data[p]. Register 0 is never forwarded.
  - Otherwise scan slots 0..DEPTH-1; the first entry with v=1 and rd==src_addr[p] wins (youngest first).
  - Winner is slot k with ok=1: fwd_sel=k+1, fwd_data=slot data.
  - Winner is slot 0 with ok=0 and ld_valid=1: fwd_sel=1, fwd_data=ld_data (bypass).
  - Winner has ok=0 and the bypass case does not apply: port hazard=1, fwd_sel=k+1, fwd_data=rf_data[p] (don't-care).
  - No winner: fwd_sel=0, fwd_data=rf_data[p].
- **Outputs:**
  - stall = OR of all port hazards.
  - mem_wait = slot0.v & ~slot0.ok & ~ld_valid.
- **Integration rule:** the pipeline must drive adv=0 while mem_wait=1. If adv=1 while mem_wait=1, the entry moves on with ok=0 and dependants keep stalling until it leaves slot DEPTH-1. This is defined behaviour, not an error.
- **Counters:** increment only on an adv=1 edge and saturate at 0xFFFF.

## Timing
- Resolution is combinational from slot state, iss_*-independent inputs and ld_*. There is zero added latency on fwd_data, fwd_sel, stall and mem_wait.
- A producer issued at edge N is forwardable from cycle N+1 (slot 0) until it shifts out after DEPTH adv edges.
- A load issued at edge N stalls a dependant in cycle N+1 unless ld_valid=1 in that cycle. Only one bubble is inserted when memory answers next cycle.
- When stall=1 and adv=1, iss_valid is masked, so slot 0 receives a bubble.
- **Reset:** synchronous; overrides adv and ld_valid. After reset all v=0 and counters are 0. Resulting outputs: fwd_sel=0, fwd_data=rf_data, stall=0, mem_wait=0. A reset mid-stall drops stall in the next cycle.

## Test plan
- **Reset:** load slots, then assert reset for 1 cycle -> all fwd_sel=0, stall=0, mem_wait=0, fwd_cnt=stall_cnt=0; fwd_data equals rf_data.
- **EX→EX forward:** issue rd=5, data=0x1234 (ALU); next cycle src_addr[0]=5 -> fwd_sel[0]=1, fwd_data[0]=0x1234. After a second adv -> fwd_sel=2. After a third -> fwd_sel=0.
- **Youngest wins:** issue rd=7=0xA, then rd=7=0xB; port 1 src=7 -> fwd_sel[1]=1, data 0xB. src_addr=0 with rd=0 in flight -> fwd_sel=0.
- **Load-use:** issue load rd=3, src=3, ld_valid=0 -> stall=1, mem_wait=1. Hold adv=0 for 2 cycles. Then ld_valid=1, ld_data=0xDEAD -> stall=0, fwd_data=0xDEAD. Next cycle slot 0 has ok=1.
- **Stall bubble:** stall=1 with adv=1 and iss_valid=1, rd=9 -> slot 0 is invalid and src=9 next cycle gives fwd_sel=0. stall_cnt increments by 1.
- **Counter saturation:** preload or drive 65536 forwarding adv cycles -> fwd_cnt holds at 0xFFFF.
